// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: default widths,
// requester identifiers and access-op encodings.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF   = 30;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 512;
  localparam int unsigned MAX_WAIT_DEF = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the EXT port has waited; signals
// when EXT must override the CPU's fixed priority.
module arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_req,
  input  logic ext_issue,
  output logic ext_override
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || !ext_req || ext_issue) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign ext_override = (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU has fixed
// priority, EXT is guaranteed a slot by the starvation counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CpuReq,
  input  logic              CpuWEN,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuAck,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuStall,
  input  logic              ExtReq,
  input  logic              ExtWEN,
  input  logic [ADDR_W-1:0] ExtAddr,
  input  logic [DATA_W-1:0] ExtWData,
  output logic              ExtAck,
  output logic [DATA_W-1:0] ExtRData,
  output logic              MemEN,
  output logic              MemWEN,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              ErrFlag
);

  logic              inflight_q, owner_q, op_q, oor_q, err_q;
  logic              cpu_elig, ext_elig, issue, win, win_wen, in_range;
  logic              ext_override, ack_ok, rd_ok;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk          (CLOCK),
    .rst          (RESET),
    .ext_req      (ExtReq),
    .ext_issue    (issue && (win == REQ_EXT)),
    .ext_override (ext_override)
  );

  // Reset gates issue and every output so nothing leaks during the reset cycle.
  always_comb begin
    cpu_elig  = !RESET && CpuReq && !(inflight_q && owner_q == REQ_CPU);
    ext_elig  = !RESET && ExtReq && !(inflight_q && owner_q == REQ_EXT);
    issue     = cpu_elig || ext_elig;
    if (cpu_elig && ext_elig) win = ext_override ? REQ_EXT : REQ_CPU;
    else                      win = ext_elig ? REQ_EXT : REQ_CPU;
    win_addr  = (win == REQ_EXT) ? ExtAddr  : CpuAddr;
    win_wdata = (win == REQ_EXT) ? ExtWData : CpuWData;
    win_wen   = (win == REQ_EXT) ? ExtWEN   : CpuWEN;
    in_range  = 64'(win_addr) < 64'(DEPTH);

    MemEN     = issue;
    MemWEN    = issue && win_wen && in_range;
    MemAddr   = issue ? win_addr  : '0;
    MemWData  = issue ? win_wdata : '0;

    ack_ok    = !RESET && inflight_q;
    rd_ok     = ack_ok && op_q == OP_RD && !oor_q;
    CpuAck    = ack_ok && owner_q == REQ_CPU;
    ExtAck    = ack_ok && owner_q == REQ_EXT;
    CpuRData  = (CpuAck && rd_ok) ? MemRData : '0;
    ExtRData  = (ExtAck && rd_ok) ? MemRData : '0;
    CpuStall  = !RESET && CpuReq && !CpuAck;
    ErrFlag   = !RESET && err_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      inflight_q <= 1'b0;
      owner_q    <= REQ_CPU;
      op_q       <= OP_RD;
      oor_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= issue;
      owner_q    <= win;
      op_q       <= win_wen ? OP_WR : OP_RD;
      oor_q      <= issue && !in_range;
      err_q      <= err_q || (issue && !in_range);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of the arbitration, ack timing and memory contents.
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int DEPTH = 512;
  localparam int MAXW = 4;

  logic          CLOCK, RESET;
  logic          CpuReq, CpuWEN, CpuAck, CpuStall;
  logic [AW-1:0] CpuAddr;
  logic [DW-1:0] CpuWData, CpuRData;
  logic          ExtReq, ExtWEN, ExtAck;
  logic [AW-1:0] ExtAddr;
  logic [DW-1:0] ExtWData, ExtRData;
  logic          MemEN, MemWEN, ErrFlag;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, MemRData;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .CpuReq(CpuReq), .CpuWEN(CpuWEN), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData), .CpuStall(CpuStall),
    .ExtReq(ExtReq), .ExtWEN(ExtWEN), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
    .ExtAck(ExtAck), .ExtRData(ExtRData),
    .MemEN(MemEN), .MemWEN(MemWEN), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .ErrFlag(ErrFlag)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000);
  endfunction

  // Memory attached to the port: registered read, reloaded on reset.
  logic [31:0] mem [DEPTH];
  always @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (MemEN) begin
      if (MemWEN) mem[MemAddr[8:0]] <= MemWData;
      MemRData <= (MemAddr < 30'd512) ? mem[MemAddr[8:0]] : 32'h0;
    end
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model state: owner of the access to be acked this cycle (-1 none).
  int          m_owner = -1;
  logic [31:0] m_ackdata = '0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  logic [31:0] gold [DEPTH];

  int          e_win;
  bit          e_cpu_ack, e_ext_ack, e_stall, e_mem_en, e_mem_wen, e_err;
  logic [31:0] e_cpu_rdata, e_ext_rdata;
  logic [AW-1:0] w_addr;
  logic [31:0] w_data;
  bit          w_wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    bit cpu_el, ext_el;
    #1;
    cpu_el = !RESET && CpuReq && m_owner != 0;
    ext_el = !RESET && ExtReq && m_owner != 1;
    if (cpu_el && ext_el) e_win = (m_wait == MAXW) ? 1 : 0;
    else if (cpu_el)      e_win = 0;
    else if (ext_el)      e_win = 1;
    else                  e_win = -1;
    w_addr = (e_win == 1) ? ExtAddr  : CpuAddr;
    w_data = (e_win == 1) ? ExtWData : CpuWData;
    w_wen  = (e_win == 1) ? ExtWEN   : CpuWEN;
    e_cpu_ack   = !RESET && m_owner == 0;
    e_ext_ack   = !RESET && m_owner == 1;
    e_cpu_rdata = e_cpu_ack ? m_ackdata : 32'h0;
    e_ext_rdata = e_ext_ack ? m_ackdata : 32'h0;
    e_stall     = !RESET && CpuReq && !e_cpu_ack;
    e_mem_en    = e_win >= 0;
    e_mem_wen   = e_mem_en && w_wen && (w_addr < DEPTH);
    e_err       = !RESET && m_err;
    chk({tag, ".CpuAck"},   CpuAck,   e_cpu_ack);
    chk({tag, ".ExtAck"},   ExtAck,   e_ext_ack);
    chk({tag, ".CpuRData"}, CpuRData, e_cpu_rdata);
    chk({tag, ".ExtRData"}, ExtRData, e_ext_rdata);
    chk({tag, ".CpuStall"}, CpuStall, e_stall);
    chk({tag, ".MemEN"},    MemEN,    e_mem_en);
    chk({tag, ".MemWEN"},   MemWEN,   e_mem_wen);
    chk({tag, ".MemAddr"},  MemAddr,  e_mem_en ? w_addr : '0);
    chk({tag, ".MemWData"}, MemWData, e_mem_en ? w_data : '0);
    chk({tag, ".ErrFlag"},  ErrFlag,  e_err);
    chk({tag, ".WaitCnt"},  dut.u_starve.wait_cnt, m_wait);
  endtask

  task automatic advance();
    bit in_rng;
    if (RESET) begin
      m_owner = -1;
      m_wait  = 0;
      m_err   = 1'b0;
      for (int i = 0; i < DEPTH; i++) gold[i] = init_word(i);
    end else begin
      if (e_win >= 0) begin
        in_rng    = w_addr < DEPTH;
        m_owner   = e_win;
        m_ackdata = (!w_wen && in_rng) ? gold[w_addr[8:0]] : 32'h0;
        if (w_wen && in_rng) gold[w_addr[8:0]] = w_data;
        if (!in_rng) m_err = 1'b1;
      end else begin
        m_owner = -1;
      end
      if (!ExtReq || e_win == 1) m_wait = 0;
      else if (m_wait < MAXW)    m_wait = m_wait + 1;
    end
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom % 10 == 0) ? AW'(512 + $urandom % 200) : AW'($urandom % 512);
  endfunction

  task automatic new_cpu();
    CpuReq = 1'b1; CpuWEN = 1'($urandom % 2); CpuAddr = rand_addr(); CpuWData = $urandom;
  endtask

  task automatic new_ext();
    ExtReq = 1'b1; ExtWEN = 1'($urandom % 2); ExtAddr = rand_addr(); ExtWData = $urandom;
  endtask

  // Lets outstanding requests complete, dropping each Req after its ack.
  task automatic drain(input string tag);
    for (int k = 0; k < 6; k++) begin
      if (e_cpu_ack) CpuReq = 1'b0;
      if (e_ext_ack) ExtReq = 1'b0;
      check_cycle(tag);
      advance();
    end
  endtask

  initial begin
    int ext_cycle;
    RESET = 1'b1;
    CpuReq = 1'b0; CpuWEN = 1'b0; CpuAddr = '0; CpuWData = '0;
    ExtReq = 1'b0; ExtWEN = 1'b0; ExtAddr = '0; ExtWData = '0;
    MemRData = '0;
    @(posedge CLOCK);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_cycle("reset");
      advance();
    end
    RESET = 1'b0;

    // Test 1: CPU read of word 5.
    CpuReq = 1'b1; CpuWEN = 1'b0; CpuAddr = 30'd5;
    check_cycle("t1c0");
    chk("t1.issue_en", MemEN, 1'b1);
    chk("t1.issue_addr", MemAddr, 30'd5);
    chk("t1.stall0", CpuStall, 1'b1);
    advance();
    check_cycle("t1c1");
    chk("t1.ack", CpuAck, 1'b1);
    chk("t1.rdata", CpuRData, 32'hDEADBEEF);
    chk("t1.stall1", CpuStall, 1'b0);
    advance();
    CpuReq = 1'b0;
    check_cycle("t1c2");
    advance();

    // Test 2: simultaneous CPU write and EXT read of word 3.
    CpuReq = 1'b1; CpuWEN = 1'b1; CpuAddr = 30'd3; CpuWData = 32'h11;
    ExtReq = 1'b1; ExtWEN = 1'b0; ExtAddr = 30'd3;
    check_cycle("t2c0");
    chk("t2.cpu_wen", MemWEN, 1'b1);
    advance();
    check_cycle("t2c1");
    chk("t2.cpu_ack", CpuAck, 1'b1);
    chk("t2.ext_issue", MemEN, 1'b1);
    chk("t2.ext_wen", MemWEN, 1'b0);
    advance();
    CpuReq = 1'b0;
    check_cycle("t2c2");
    chk("t2.ext_ack", ExtAck, 1'b1);
    chk("t2.ext_rdata", ExtRData, 32'h11);
    advance();
    ExtReq = 1'b0;
    check_cycle("t2c3");
    advance();

    // Test 3: CPU back-to-back requests with EXT held high.
    ext_cycle = -1;
    ExtReq = 1'b1; ExtWEN = 1'b0; ExtAddr = 30'd7;
    new_cpu();
    CpuAddr = AW'($urandom % 512);
    for (int c = 0; c < 8; c++) begin
      if (c > 0 && e_cpu_ack) begin
        new_cpu();
        CpuAddr = AW'($urandom % 512);
      end
      if (c > 0 && e_ext_ack) ExtReq = 1'b0;
      check_cycle("t3");
      if (e_win == 1 && ext_cycle < 0) ext_cycle = c;
      advance();
    end
    chk("t3.ext_by_4", (ext_cycle >= 0 && ext_cycle <= 4), 1'b1);
    drain("t3drain");

    // Test 4: out-of-range EXT write, sticky ErrFlag.
    ExtReq = 1'b1; ExtWEN = 1'b1; ExtAddr = 30'd600; ExtWData = 32'hAB;
    check_cycle("t4c0");
    chk("t4.en", MemEN, 1'b1);
    chk("t4.wen", MemWEN, 1'b0);
    advance();
    check_cycle("t4c1");
    chk("t4.ack", ExtAck, 1'b1);
    chk("t4.err", ErrFlag, 1'b1);
    advance();
    ExtReq = 1'b0;
    CpuReq = 1'b1; CpuWEN = 1'b0; CpuAddr = 30'd5;
    check_cycle("t4c2");
    advance();
    check_cycle("t4c3");
    chk("t4.err_hold", ErrFlag, 1'b1);
    advance();
    CpuReq = 1'b0;
    check_cycle("t4c4");
    advance();

    // Test 5: reset the cycle after a CPU read issues.
    CpuReq = 1'b1; CpuWEN = 1'b0; CpuAddr = 30'd9;
    check_cycle("t5c0");
    advance();
    RESET = 1'b1;
    check_cycle("t5c1");
    chk("t5.no_ack", CpuAck, 1'b0);
    chk("t5.en0", MemEN, 1'b0);
    chk("t5.err0", ErrFlag, 1'b0);
    advance();
    RESET = 1'b0;
    check_cycle("t5c2");
    chk("t5.reissue", MemEN, 1'b1);
    chk("t5.no_ack2", CpuAck, 1'b0);
    advance();
    check_cycle("t5c3");
    chk("t5.ack", CpuAck, 1'b1);
    chk("t5.rdata", CpuRData, init_word(9));
    advance();
    CpuReq = 1'b0;
    check_cycle("t5c4");
    advance();

    // Test 6: idle.
    for (int k = 0; k < 10; k++) begin
      check_cycle("t6");
      chk("t6.idle_en", MemEN, 1'b0);
      advance();
    end

    // Randomized traffic from both ports.
    for (int c = 0; c < 500; c++) begin
      if (e_cpu_ack) begin
        if ($urandom % 4 != 0) new_cpu(); else CpuReq = 1'b0;
      end else if (!CpuReq && $urandom % 5 < 2) new_cpu();
      if (e_ext_ack) begin
        if ($urandom % 4 != 0) new_ext(); else ExtReq = 1'b0;
      end else if (!ExtReq && $urandom % 5 < 2) new_ext();
      check_cycle("rnd");
      advance();
    end
    drain("rnddrain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
